// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//
// Memory-access stage plus MEM/WB pipeline register for a 16-bit pipeline.
// A load or store presented by the EX/MEM register is issued to data memory
// combinationally. While the memory has not acknowledged, the stage stalls
// everything upstream and inserts bubbles into write-back. A small two-state
// FSM counts WAIT cycles. When the count reaches TIMEOUT, the access is
// abandoned and a sticky error flag is raised.
//
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   ALUResultM          : ALU result / memory address from EX/MEM
//   WriteDataM          : store data
//   WriteRegM           : destination register index
//   RegWriteM           : instruction writes the register file
//   MemWriteM/MemReadM  : store / load request
//   NM, VM, ZM          : condition flags from EX/MEM
//   mem_req, mem_we     : data-memory request and write strobe
//   mem_addr, mem_wdata : data-memory address and write data
//   mem_rdata, mem_ack  : data-memory read data and completion
//   StallM              : freeze fetch, decode, EX and EX/MEM registers
//   ResultW, WriteRegW  : write-back value and register index
//   RegWriteW           : register-file write enable
//   NW, VW, ZW          : registered flags
//   mem_err             : sticky memory-timeout error
// ---------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ALUResultM,
  input  logic [15:0] WriteDataM,
  input  logic [2:0]  WriteRegM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic        NM,
  input  logic        VM,
  input  logic        ZM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        StallM,
  output logic [15:0] ResultW,
  output logic [2:0]  WriteRegW,
  output logic        RegWriteW,
  output logic        NW,
  output logic        VW,
  output logic        ZW,
  output logic        mem_err
);

  // The WAIT counter is 4 bits wide, so TIMEOUT is taken modulo 16.
  localparam logic [3:0] TimeoutCnt = 4'(TIMEOUT);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        memErr_q, memErr_d;

  logic [15:0] resultW_q;
  logic [2:0]  writeRegW_q;
  logic        regWriteW_q;
  logic        nW_q, vW_q, zW_q;

  logic        accessPending;
  logic        isLoad;
  logic        timeoutHit;

  // When both strobes are set, the access is a store, so a load means read-only.
  assign accessPending = MemReadM | MemWriteM;
  assign isLoad        = MemReadM & ~MemWriteM;
  assign timeoutHit    = (state_q == WAIT) && (cnt_q == TimeoutCnt);

  // Address and data are passed straight through. Upstream holds them stable
  // during a stall, so nothing is re-latched here.
  assign mem_addr  = ALUResultM;
  assign mem_wdata = WriteDataM;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      memErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      memErr_q <= memErr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    memErr_d = memErr_q | timeoutHit;
    unique case (state_q)
      IDLE: begin
        // mem_ack is ignored without a request, so the FSM only leaves IDLE
        // for a real, unacknowledged access.
        if (accessPending && !mem_ack) begin
          state_d = WAIT;
          cnt_d   = 4'd0;
        end
      end
      WAIT: begin
        if (!accessPending || mem_ack || timeoutHit) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'hF) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs
  // ---------------------------------------------------------------------------
  // The request is identical in IDLE and WAIT: it follows the EX/MEM inputs.
  // This lets a zero-wait memory finish in the issue cycle without stalling.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    StallM  = 1'b0;
    if (accessPending) begin
      mem_req = 1'b1;
      mem_we  = MemWriteM;
      StallM  = ~mem_ack & ~timeoutHit;
    end
  end

  // ---------------------------------------------------------------------------
  // MEM/WB pipeline register
  // ---------------------------------------------------------------------------
  // A stalled edge inserts a bubble by clearing only the write enable. The
  // data fields hold their previous contents. An aborted (timed-out) access
  // still advances, but it is not allowed to write the register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resultW_q   <= 16'd0;
      writeRegW_q <= 3'd0;
      regWriteW_q <= 1'b0;
      nW_q        <= 1'b0;
      vW_q        <= 1'b0;
      zW_q        <= 1'b0;
    end else if (!StallM) begin
      resultW_q   <= isLoad ? mem_rdata : ALUResultM;
      writeRegW_q <= WriteRegM;
      regWriteW_q <= RegWriteM & ~MemWriteM & ~timeoutHit;
      nW_q        <= NM;
      vW_q        <= VM;
      zW_q        <= ZM;
    end else begin
      regWriteW_q <= 1'b0;
    end
  end

  assign ResultW   = resultW_q;
  assign WriteRegW = writeRegW_q;
  assign RegWriteW = regWriteW_q;
  assign NW        = nW_q;
  assign VW        = vW_q;
  assign ZW        = zW_q;
  assign mem_err   = memErr_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Self-checking bench for mem_wb_stage. Each transaction is held on the EX/MEM
// inputs until the stage stops stalling. This is the upstream behaviour the
// stage relies on. A responder acknowledges a set number of cycles after the
// request starts. The reference model works in terms of whole accesses:
//   - how many cycles the access has been outstanding
//   - whether that count has reached the timeout limit
//   - what the write-back registers should contain once the access retires
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

  localparam int TIMEOUT = 15;
  localparam int NEVER   = 99;

  logic        clk;
  logic        reset;
  logic [15:0] ALUResultM;
  logic [15:0] WriteDataM;
  logic [2:0]  WriteRegM;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        MemReadM;
  logic        NM, VM, ZM;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        StallM;
  logic [15:0] ResultW;
  logic [2:0]  WriteRegW;
  logic        RegWriteW;
  logic        NW, VW, ZW;
  logic        mem_err;

  int          assertCount = 0;
  int          failCount   = 0;

  // Reference-model state
  int          outstanding;
  int          ackAfter;
  logic [15:0] loadData;
  logic [15:0] expResult;
  logic [2:0]  expWreg;
  logic        expRw, expN, expV, expZ, expErr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_wb_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .WriteRegM  (WriteRegM),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .NM         (NM),
    .VM         (VM),
    .ZM         (ZM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .StallM     (StallM),
    .ResultW    (ResultW),
    .WriteRegW  (WriteRegW),
    .RegWriteW  (RegWriteW),
    .NW         (NW),
    .VW         (VW),
    .ZW         (ZW),
    .mem_err    (mem_err)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkRegs(input string ph);
    checkOutput({ph, ".ResultW"},   ResultW,          expResult);
    checkOutput({ph, ".WriteRegW"}, 16'(WriteRegW),   16'(expWreg));
    checkOutput({ph, ".RegWriteW"}, 16'(RegWriteW),   16'(expRw));
    checkOutput({ph, ".flags"},     16'({NW, VW, ZW}), 16'({expN, expV, expZ}));
    checkOutput({ph, ".mem_err"},   16'(mem_err),     16'(expErr));
  endtask

  task automatic clearModel();
    expResult = 16'd0;
    expWreg   = 3'd0;
    expRw     = 1'b0;
    expN      = 1'b0;
    expV      = 1'b0;
    expZ      = 1'b0;
    expErr    = 1'b0;
  endtask

  // Run one clock cycle of the current access. Called #1 after a rising edge.
  // Returns after the next rising edge (+#1) with the model updated.
  task automatic doCycle(output bit stalled);
    logic pending, isLoad, timedOut, expStall;
    pending = MemReadM | MemWriteM;
    isLoad  = MemReadM & ~MemWriteM;
    if (pending) begin
      mem_ack   = (outstanding == ackAfter);
      mem_rdata = mem_ack ? loadData : 16'($urandom);
    end else begin
      // Noise on mem_ack without a request must have no effect.
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
    end
    // Cycle 0 is the issue cycle. Cycles 1..TIMEOUT+1 are counted waits,
    // and the last of those is the abort cycle.
    timedOut = pending && (outstanding == TIMEOUT + 1);
    expStall = pending && !mem_ack && !timedOut;
    #1;
    checkOutput("mem_req",   16'(mem_req), 16'(pending));
    checkOutput("mem_we",    16'(mem_we),  16'(pending && MemWriteM));
    checkOutput("mem_addr",  mem_addr,     ALUResultM);
    checkOutput("mem_wdata", mem_wdata,    WriteDataM);
    checkOutput("StallM",    16'(StallM),  16'(expStall));
    @(posedge clk);
    #1;
    if (expStall) begin
      expRw = 1'b0;
    end else begin
      expResult = isLoad ? mem_rdata : ALUResultM;
      expWreg   = WriteRegM;
      expRw     = RegWriteM && !MemWriteM && !timedOut;
      expN      = NM;
      expV      = VM;
      expZ      = ZM;
    end
    if (timedOut) expErr = 1'b1;
    checkRegs("wb");
    stalled     = expStall;
    outstanding = expStall ? outstanding + 1 : 0;
  endtask

  task automatic setInputs(input logic [15:0] alu, input logic [15:0] wdata,
                           input logic [2:0] wreg, input logic rw,
                           input logic mw, input logic mr,
                           input logic [2:0] nvz);
    ALUResultM = alu;
    WriteDataM = wdata;
    WriteRegM  = wreg;
    RegWriteM  = rw;
    MemWriteM  = mw;
    MemReadM   = mr;
    {NM, VM, ZM} = nvz;
  endtask

  // Holds one instruction until the stage stops stalling, then checks how
  // long the stall lasted.
  task automatic applyStimulus(input string name, input logic [15:0] alu,
                               input logic [15:0] wdata, input logic [2:0] wreg,
                               input logic rw, input logic mw, input logic mr,
                               input logic [2:0] nvz, input int latency,
                               input logic [15:0] rdata);
    bit st;
    bit done;
    int stallCnt;
    int expStalls;
    setInputs(alu, wdata, wreg, rw, mw, mr, nvz);
    ackAfter    = latency;
    loadData    = rdata;
    outstanding = 0;
    stallCnt    = 0;
    done        = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      doCycle(st);
      if (st) stallCnt++;
      else    done = 1;
    end
    if (!done) checkOutput({name, ".bound"}, 16'(0), 16'(1));
    if (mw || mr) expStalls = (latency > TIMEOUT + 1) ? TIMEOUT + 1 : latency;
    else          expStalls = 0;
    checkOutput({name, ".stallLen"}, 16'(stallCnt), 16'(expStalls));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit st;
    bit done;
    int typ;
    int lat;

    reset     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 16'd0;
    setInputs(16'd0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    clearModel();
    #3;
    checkRegs("reset");
    checkOutput("reset.mem_req", 16'(mem_req), 16'(0));
    #9 reset = 1'b1;
    @(posedge clk);
    #1;
    checkRegs("post_reset");

    // Plain ALU op.
    applyStimulus("alu",      16'h1234, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b0, 3'b001, 0, 16'h0);
    checkOutput("alu.ResultW", ResultW, 16'h1234);
    // Zero-wait load.
    applyStimulus("load0",    16'h0040, 16'h0000, 3'd5, 1'b1, 1'b0, 1'b1, 3'b100, 0, 16'hBEEF);
    checkOutput("load0.ResultW", ResultW, 16'hBEEF);
    // Load with three wait cycles.
    applyStimulus("load3",    16'h0042, 16'h0000, 3'd6, 1'b1, 1'b0, 1'b1, 3'b010, 3, 16'h5A5A);
    checkOutput("load3.ResultW", ResultW, 16'h5A5A);
    // Store with one wait cycle. RegWriteM is set but must not take effect.
    applyStimulus("store1",   16'h0010, 16'h00AA, 3'd2, 1'b1, 1'b1, 1'b0, 3'b000, 1, 16'h0);
    // Load that never completes.
    applyStimulus("timeout",  16'h0080, 16'h0000, 3'd4, 1'b1, 1'b0, 1'b1, 3'b011, NEVER, 16'h0);
    checkOutput("timeout.RegWriteW", 16'(RegWriteW), 16'(0));
    checkOutput("timeout.mem_err",   16'(mem_err),   16'(1));
    // Later accesses still work, and the error stays set.
    applyStimulus("after_to", 16'h0090, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b1, 3'b000, 2, 16'hC0DE);
    checkOutput("after_to.mem_err", 16'(mem_err), 16'(1));
    // Both strobes set: treated as a store.
    applyStimulus("both",     16'h0020, 16'h1111, 3'd7, 1'b1, 1'b1, 1'b1, 3'b111, 1, 16'h2222);

    // Reset while waiting, then the still-pending load restarts.
    setInputs(16'h0100, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b1, 3'b101);
    ackAfter    = NEVER;
    loadData    = 16'h0;
    outstanding = 0;
    for (int c = 0; c < 3; c++) doCycle(st);
    reset = 1'b0;
    #2;
    clearModel();
    checkRegs("mid_reset");
    checkOutput("mid_reset.StallM_hold", 16'(mem_req), 16'(1));
    #1 reset = 1'b1;
    ackAfter    = 2;
    loadData    = 16'h7777;
    outstanding = 0;
    done        = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      doCycle(st);
      if (!st) done = 1;
    end
    if (!done) checkOutput("restart.bound", 16'(0), 16'(1));
    checkOutput("restart.ResultW", ResultW, 16'h7777);

    // Random mix of ALU ops, loads, stores and occasional timeouts.
    for (int i = 0; i < 40; i++) begin
      typ = $urandom_range(0, 3);
      lat = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 4);
      applyStimulus("rand", 16'($urandom), 16'($urandom), 3'($urandom),
                    1'($urandom), typ[1], (typ == 1) || (typ == 3),
                    3'($urandom), lat, 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset; reset low clears all state immediately
- ALUResultM  in  16  EX/MEM ALU result; also the memory address
- WriteDataM  in  16  store data
- WriteRegM  in  3  destination register index
- RegWriteM  in  1  instruction writes the register file
- MemWriteM  in  1  store
- MemReadM  in  1  load
- NM, VM, ZM  in  1 each  flags from EX/MEM
- mem_req  out  1  data-memory request
- mem_we  out  1  request is a write
- mem_addr  out  16  equals ALUResultM
- mem_wdata  out  16  equals WriteDataM
- mem_rdata  in  16  read data, valid when mem_ack=1
- mem_ack  in  1  memory completes the request this cycle
- StallM  out  1  hold fetch, decode, EX and EX/MEM registers
- ResultW  out  16  write-back value
- WriteRegW  out  3  write-back register index
- RegWriteW  out  1  register-file write enable
- NW, VW, ZW  out  1 each  registered flags
- mem_err  out  1  sticky memory-timeout error
REQ-002 The block SHALL have one parameter, TIMEOUT, default 15: the maximum number of WAIT-state cycles before abort.

Function
REQ-003 The FSM SHALL have two states: IDLE and WAIT.
REQ-004 An access SHALL be pending when (MemReadM | MemWriteM) = 1; if both are set, the access SHALL be treated as a write.
REQ-005 In IDLE and WAIT with an access pending, mem_req SHALL be 1 combinationally, with mem_we = MemWriteM, mem_addr = ALUResultM, mem_wdata = WriteDataM.
REQ-006 With no access pending, mem_req and mem_we SHALL be 0.
REQ-007 StallM SHALL equal mem_req & ~mem_ack & ~timeout_hit, where timeout_hit = (state==WAIT & cnt==TIMEOUT).
REQ-008 In IDLE with an access pending and mem_ack=0, the next state SHALL be WAIT, with cnt cleared to 0.
REQ-009 In WAIT with mem_ack=0 and cnt<TIMEOUT, the FSM SHALL stay in WAIT and increment cnt (4-bit, saturating, never wraps).
REQ-010 In any state, when the access completes (mem_ack=1 while mem_req=1), the next state SHALL be IDLE.
REQ-011 A zero-wait memory (ack in the request cycle) SHALL cause no stall, giving 1-cycle MEM latency.
REQ-012 On a timeout_hit, the FSM SHALL:
- return to IDLE
- set mem_err to 1
- release the stall
- give the aborted instruction RegWriteW=0
REQ-013 mem_ack SHALL be ignored while mem_req=0.
REQ-014 The write-back registers (ResultW, WriteRegW, RegWriteW, NW/VW/ZW) SHALL load on every clock edge with StallM=0:
- ResultW = mem_rdata for a load, else ALUResultM
- RegWriteW = RegWriteM & ~MemWriteM & ~timeout_hit
- other fields copied from the M-stage inputs
REQ-015 On a clock edge with StallM=1, the block SHALL insert a bubble: RegWriteW=0, while ResultW, WriteRegW and the flags hold their values.
REQ-016 Inputs SHALL be sampled as held stable by upstream while StallM=1; the block SHALL NOT re-latch address or data.
REQ-017 mem_err SHALL be sticky and cleared only by reset.

Reset
REQ-018 While reset=0, the block SHALL force all of the following, independent of clk:
- state=IDLE, cnt=0, mem_err=0
- ResultW=0, WriteRegW=0, RegWriteW=0, NW=VW=ZW=0
REQ-019 Reset asserted mid-WAIT SHALL abandon the access; after release mem_req follows only the current inputs.
REQ-020 The first rising edge after reset deasserts SHALL behave as a normal IDLE cycle.

Verification
REQ-021 A bench SHALL cover these directed scenarios:
- ALU op ALUResultM=0x1234, WriteRegM=3, RegWriteM=1, no mem -> next edge ResultW=0x1234, WriteRegW=3, RegWriteW=1, mem_req=0, StallM=0.
- Load at 0x0040, mem_ack same cycle with mem_rdata=0xBEEF -> StallM never 1; next edge ResultW=0xBEEF, RegWriteW=1.
- Load, ack after 3 cycles -> StallM=1 for exactly 3 cycles; 3 bubble edges with RegWriteW=0; then ResultW=mem_rdata, RegWriteW=1.
- Store 0x00AA to 0x0010 with RegWriteM=1, ack after 1 cycle -> mem_we=1, mem_wdata=0x00AA for 2 cycles; RegWriteW stays 0.
- Load, no ack for TIMEOUT+1 cycles -> StallM drops in the cycle with cnt=15; mem_err=1 and stays 1; RegWriteW=0; later accesses still work.
- reset driven low during WAIT between clock edges -> all outputs 0 and state IDLE immediately; after release, a pending load restarts its request.
